bus_arbiter4: RTL and testbench

Round-robin arbiter that shares one 32-bit datapath resource among four requesters. It drives the 2-bit select of the 4:1 32-bit datapath multiplexer in front of the shared resource and returns a one-hot grant to each requester. Ownership is held while the owner keeps requesting, bounded by a programmable hold limit when others are waiting. It sits between the requesting units and the shared-resource select input.

---
 rtl/bus_arbiter4.sv | 117 +++++++++++
 tb/tb_bus_arbiter4.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Four-way round-robin arbiter for a shared 32-bit datapath. It drives the mux select
// and one-hot grants, and bounds how long one owner holds the grant while others wait.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] S,
    output logic       BUSY
);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_HOLD);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_s, w_s_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy;
    logic [3:0]       w_others;
    logic [1:0]       w_win_all;
    logic [1:0]       w_win_oth;

    // First set request after p, in the order p+1 .. p+4 (mod 4).
    function automatic logic [1:0] f_scan(input logic [1:0] p, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // While owning, PTR always equals the owner's index.
    assign w_others  = REQ & ~(4'b0001 << r_ptr);
    assign w_win_all = f_scan(r_ptr, REQ);
    assign w_win_oth = f_scan(r_ptr, w_others);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_s_nxt     = r_s;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (REQ != 4'b0000) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = 4'b0001 << w_win_all;
                    w_s_nxt     = w_win_all;
                    w_ptr_nxt   = w_win_all;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (!REQ[r_ptr]) begin
                    if (REQ != 4'b0000) begin
                        w_gnt_nxt = 4'b0001 << w_win_all;
                        w_s_nxt   = w_win_all;
                        w_ptr_nxt = w_win_all;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (r_cnt != LP_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (w_others != 4'b0000) begin
                    w_gnt_nxt = 4'b0001 << w_win_oth;
                    w_s_nxt   = w_win_oth;
                    w_ptr_nxt = w_win_oth;
                    w_cnt_nxt = CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_s     <= '0;
            r_ptr   <= 2'b11;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_s     <= w_s_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_OWN);
        end
    end

    assign GNT  = r_gnt;
    assign S    = r_s;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Testbench for bus_arbiter4: directed scenarios plus randomized traffic checked
// against an owner/pointer reference model written with plain integers.
module tb_bus_arbiter4;

    localparam int HOLD = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] S;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index or -1 when idle.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 3;
    int m_s     = 0;

    bus_arbiter4 #(.MAX_HOLD(HOLD), .CNT_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .GNT (GNT),
        .S   (S),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int scan(input int p, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] req);
        int w;
        logic [3:0] oth;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_ptr = 3; m_s = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                w = scan(m_ptr, req);
                m_owner = w; m_cnt = 1; m_ptr = w; m_s = w;
            end
        end else if (!req[m_owner]) begin
            w = scan(m_owner, req);
            if (w < 0) m_owner = -1;
            else begin m_owner = w; m_cnt = 1; m_ptr = w; m_s = w; end
        end else if (m_cnt < HOLD) begin
            m_cnt++;
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            if (oth != 0) begin
                w = scan(m_owner, oth);
                m_owner = w; m_cnt = 1; m_ptr = w; m_s = w;
            end
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle away from the edge.
    task automatic cycle(input logic rst, input logic [3:0] req);
        RST = rst;
        REQ = req;
        @(posedge CLK);
        model_step(rst, req);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        total++;
        if (GNT !== 4'b0000 || S !== 2'd0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_state gnt=%b s=%0d busy=%b exp 0000/0/0", GNT, S, BUSY);
        end
        cycle(1'b0, 4'b1111);
        total++;
        if (GNT !== 4'b0001 || S !== 2'd0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant gnt=%b s=%0d busy=%b exp 0001/0/1", GNT, S, BUSY);
        end
        cycle(1'b0, 4'b0000);
    endtask

    task automatic test_single();
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0100);
            total++;
            if (GNT !== 4'b0100 || S !== 2'd2 || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL single_hold cyc=%0d gnt=%b s=%0d exp 0100/2", i, GNT, S);
            end
        end
        cycle(1'b0, 4'b0000);
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || S !== 2'd2) begin
            bad++;
            $display("FAIL single_release gnt=%b busy=%b s=%0d exp 0000/0/2", GNT, BUSY, S);
        end
    endtask

    task automatic test_handover();
        int order [3] = '{0, 1, 3};
        logic [3:0] req;
        cycle(1'b1, 4'b0000);
        req = 4'b1011;
        cycle(1'b0, req);
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 3; c++) begin
                total++;
                if (GNT !== (4'b0001 << order[n]) || S !== 2'(order[n]) || BUSY !== 1'b1) begin
                    bad++;
                    $display("FAIL handover owner=%0d c=%0d gnt=%b s=%0d busy=%b", order[n], c, GNT, S, BUSY);
                end
                if (c < 2) cycle(1'b0, req);
            end
            req[order[n]] = 1'b0;
            cycle(1'b0, req);
        end
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || S !== 2'd3) begin
            bad++;
            $display("FAIL handover_idle gnt=%b busy=%b s=%0d exp 0000/0/3", GNT, BUSY, S);
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0001);
        total++;
        if (GNT !== exp[0]) begin
            bad++;
            $display("FAIL hold_first gnt=%b exp=%b", GNT, exp[0]);
        end
        for (int i = 1; i < 9; i++) begin
            cycle(1'b0, 4'b0101);
            total++;
            if (GNT !== exp[i]) begin
                bad++;
                $display("FAIL hold_limit cyc=%0d gnt=%b exp=%b", i, GNT, exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int drops = 0;
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b0010);
            if (GNT !== 4'b0010 || S !== 2'd1) drops++;
        end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL saturation bad_cycles=%0d exp 0", drops);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b1000);
        total++;
        if (GNT !== 4'b1000 || S !== 2'd3) begin
            bad++;
            $display("FAIL mid_grant gnt=%b s=%0d exp 1000/3", GNT, S);
        end
        cycle(1'b1, 4'b1000);
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || S !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset gnt=%b busy=%b s=%0d exp 0000/0/0", GNT, BUSY, S);
        end
        cycle(1'b0, 4'b1001);
        total++;
        if (GNT !== 4'b0001 || S !== 2'd0) begin
            bad++;
            $display("FAIL mid_after gnt=%b s=%0d exp 0001/0", GNT, S);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        for (int i = 0; i < 400; i++) begin
            r  = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 59) == 0);
            cycle(rs, r);
            total++;
            if (GNT !== m_gnt() || S !== 2'(m_s) || BUSY !== (m_owner >= 0)) begin
                bad++;
                $display("FAIL random cyc=%0d req=%b gnt=%b exp=%b s=%0d exp=%0d busy=%b",
                         i, r, GNT, m_gnt(), S, m_s, BUSY);
            end
            total++;
            if (!$onehot0(GNT) || BUSY !== (|GNT) || (BUSY && GNT[S] !== 1'b1)) begin
                bad++;
                $display("FAIL invariant cyc=%0d gnt=%b s=%0d busy=%b exp onehot0/consistent", i, GNT, S, BUSY);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ = 4'b0000;
        test_reset();
        test_single();
        test_handover();
        test_hold_limit();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
